turn_controller: RTL and testbench

TURN_CONTROLLER -- requirements
Module: turn_controller

---
 rtl/game_pkg.sv | 17 +
 rtl/key_edge_detect.sv | 22 ++
 rtl/turn_controller.sv | 104 ++++++++++
 tb/tb_turn_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared turn-controller types and keyboard constants.
package game_pkg;

  typedef enum logic [2:0] {
    P1_AIM,
    P1_FLIGHT,
    SETTLE_TO_P2,
    P2_AIM,
    P2_FLIGHT,
    SETTLE_TO_P1
  } turn_state_t;

  localparam logic [7:0] KEY_C     = 8'd6;
  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam logic [7:0] FIRE_KEY  = KEY_SPACE;

endpackage

// File: rtl/key_edge_detect.sv
// New-press detector: one event per keycode change to a nonzero value.
module key_edge_detect (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic [7:0] key_event,
  output logic       key_event_valid
);

  logic [7:0] prev_keycode;

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) prev_keycode <= '0;
    else        prev_keycode <= keycode;
  end

  always_comb begin
    key_event_valid = (keycode != '0) && (keycode != prev_keycode);
    key_event       = key_event_valid ? keycode : '0;
  end

endmodule

// File: rtl/turn_controller.sv
// Two-player turn sequencer: aim, projectile flight, settle, then hand over.
// Optional aim-phase countdown/timeout enabled by defining TURN_TIMEOUT_EN.
module turn_controller
  import game_pkg::*;
#(
  parameter int TURN_FRAMES   = 600,
  parameter int SETTLE_FRAMES = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       proj_active,
  output logic       p1_in_turn,
  output logic       p2_in_turn,
  output logic [7:0] key_event,
  output logic       key_event_valid,
  output logic       fire,
  output logic [9:0] frames_left
);

  localparam logic [9:0]  TURN_INIT   = 10'(TURN_FRAMES);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_FRAMES - 1);

  turn_state_t state;
  logic        flight_min;
  logic [15:0] settle_cnt;
  logic        fire_now;

  key_edge_detect u_key_edge (
    .frame_clk       (frame_clk),
    .Reset           (Reset),
    .keycode         (keycode),
    .key_event       (key_event),
    .key_event_valid (key_event_valid)
  );

  assign fire_now = key_event_valid && (key_event == FIRE_KEY);

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state       <= P1_AIM;
      frames_left <= TURN_INIT;
      fire        <= 1'b0;
      p1_in_turn  <= 1'b1;
      p2_in_turn  <= 1'b0;
      flight_min  <= 1'b0;
      settle_cnt  <= '0;
    end else begin
      fire <= 1'b0;
      case (state)
        P1_AIM, P2_AIM: begin
          // Fire is tested first so it wins over an expiring countdown.
          if (fire_now) begin
            fire       <= 1'b1;
            state      <= (state == P1_AIM) ? P1_FLIGHT : P2_FLIGHT;
            p1_in_turn <= 1'b0;
            p2_in_turn <= 1'b0;
            flight_min <= 1'b0;
          end
`ifdef TURN_TIMEOUT_EN
          else if (frames_left == '0) begin
            state      <= (state == P1_AIM) ? SETTLE_TO_P2 : SETTLE_TO_P1;
            p1_in_turn <= 1'b0;
            p2_in_turn <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
          end else begin
            frames_left <= frames_left - 10'd1;
          end
`endif
        end
        P1_FLIGHT, P2_FLIGHT: begin
          // flight_min marks that one flight frame has already elapsed.
          if (flight_min && !proj_active) begin
            state      <= (state == P1_FLIGHT) ? SETTLE_TO_P2 : SETTLE_TO_P1;
            settle_cnt <= SETTLE_LOAD;
          end else begin
            flight_min <= 1'b1;
          end
        end
        SETTLE_TO_P2, SETTLE_TO_P1: begin
          if (settle_cnt == '0) begin
            frames_left <= TURN_INIT;
            if (state == SETTLE_TO_P2) begin
              state      <= P2_AIM;
              p2_in_turn <= 1'b1;
            end else begin
              state      <= P1_AIM;
              p1_in_turn <= 1'b1;
            end
          end else begin
            settle_cnt <= settle_cnt - 16'd1;
          end
        end
        default: begin
          state       <= P1_AIM;
          frames_left <= TURN_INIT;
          p1_in_turn  <= 1'b1;
          p2_in_turn  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turn_controller.sv
// Scoreboard bench for turn_controller against a phase/elapsed-time reference model.
module tb_turn_controller;

`ifdef TURN_TIMEOUT_EN
  localparam int  TF = 8;
  localparam bit  TO = 1'b1;
`else
  localparam int  TF = 600;
  localparam bit  TO = 1'b0;
`endif
  localparam int SF = 30;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic       proj_active;
  logic       p1_in_turn, p2_in_turn, key_event_valid, fire;
  logic [7:0] key_event;
  logic [9:0] frames_left;

  turn_controller #(.TURN_FRAMES(TF), .SETTLE_FRAMES(SF)) dut (
    .frame_clk       (frame_clk),
    .Reset           (Reset),
    .keycode         (keycode),
    .proj_active     (proj_active),
    .p1_in_turn      (p1_in_turn),
    .p2_in_turn      (p2_in_turn),
    .key_event       (key_event),
    .key_event_valid (key_event_valid),
    .fire            (fire),
    .frames_left     (frames_left)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int frame;
    bit p1;
    bit p2;
    bit fire;
    int fl;
    bit kv;
    int ke;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   frame_no = 0;

  // Reference model: whose turn, which phase (0 aim, 1 flight, 2 settle), frames spent there.
  int         m_player, m_kind, m_elapsed, m_fl;
  bit         m_fire;
  logic [7:0] m_prev;

  function automatic void chk(input string name, input int frame, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s frame %0d got %0d expected %0d", name, frame, act, expv);
    end
  endfunction

  function automatic void model_reset();
    m_player = 1; m_kind = 0; m_elapsed = 0; m_fl = TF; m_fire = 0; m_prev = 8'd0;
  endfunction

  function automatic void model_step(input logic [7:0] k, input bit p);
    bit press_fire;
    press_fire = (k != 8'd0) && (k != m_prev) && (k == 8'd44);
    m_prev = k;
    m_fire = 0;
    if (m_kind == 0) begin
      if (press_fire) begin
        m_fire = 1; m_kind = 1; m_elapsed = 0;
      end else if (TO && m_fl == 0) begin
        m_kind = 2; m_elapsed = 0; m_player = 3 - m_player;
      end else if (TO) begin
        m_fl = m_fl - 1;
      end
    end else if (m_kind == 1) begin
      m_elapsed++;
      if (m_elapsed >= 2 && !p) begin
        m_kind = 2; m_elapsed = 0; m_player = 3 - m_player;
      end
    end else begin
      m_elapsed++;
      if (m_elapsed == SF) begin
        m_kind = 0; m_elapsed = 0; m_fl = TF;
      end
    end
  endfunction

  // One frame: model absorbs the inputs seen at this edge, then new inputs are driven.
  task automatic frame(input logic [7:0] k, input bit p, input bit rst);
    exp_t e;
    @(posedge frame_clk);
    if (!Reset) model_reset();
    else        model_step(keycode, proj_active);
    #2;
    keycode = k; proj_active = p; Reset = rst;
    frame_no++;
    if (!rst) begin
      model_reset();
      #1;
      chk("async_rst_p1", frame_no, int'(p1_in_turn), 1);
      chk("async_rst_p2", frame_no, int'(p2_in_turn), 0);
      chk("async_rst_fire", frame_no, int'(fire), 0);
      chk("async_rst_frames_left", frame_no, int'(frames_left), TF);
    end
    e.frame = frame_no;
    e.p1    = (m_kind == 0) && (m_player == 1);
    e.p2    = (m_kind == 0) && (m_player == 2);
    e.fire  = m_fire;
    e.fl    = m_fl;
    e.kv    = (k != 8'd0) && (k != m_prev);
    e.ke    = e.kv ? int'(k) : 0;
    exp_q.push_back(e);
  endtask

  // Monitor: compare whatever the DUT presents mid-frame against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge frame_clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("p1_in_turn", e.frame, int'(p1_in_turn), int'(e.p1));
        chk("p2_in_turn", e.frame, int'(p2_in_turn), int'(e.p2));
        chk("p1_p2_exclusive", e.frame, int'(p1_in_turn && p2_in_turn), 0);
        chk("fire", e.frame, int'(fire), int'(e.fire));
        chk("frames_left", e.frame, int'(frames_left), e.fl);
        chk("key_event_valid", e.frame, int'(key_event_valid), int'(e.kv));
        chk("key_event", e.frame, int'(key_event), e.ke);
      end
    end
  end

  initial begin
    int r;
    logic [7:0] k;
    bit pa;
    Reset = 1'b0; keycode = 8'd0; proj_active = 1'b0;
    model_reset();

    repeat (3) frame(8'd0, 1'b0, 1'b0);
    frame(8'd0, 1'b0, 1'b1);

    // Held key: a single event.
    repeat (10) frame(8'd6, 1'b0, 1'b1);
    repeat (2) frame(8'd0, 1'b0, 1'b1);

    // P1 fires, projectile in flight 20 frames, settle, P2 aims.
    repeat (4) frame(8'd0, 1'b0, 1'b1);
    frame(8'd44, 1'b1, 1'b1);
    repeat (19) frame(8'd44, 1'b1, 1'b1);
    repeat (40) frame(8'd0, 1'b0, 1'b1);

    // P2 fires with proj_active never rising: minimum flight.
    frame(8'd44, 1'b0, 1'b1);
    repeat (40) frame(8'd0, 1'b0, 1'b1);

    // Into P2 flight, then reset mid-flight with space held across release.
    frame(8'd44, 1'b1, 1'b1);
    repeat (5) frame(8'd0, 1'b1, 1'b1);
    repeat (40) frame(8'd0, 1'b0, 1'b1);
    frame(8'd44, 1'b1, 1'b1);
    repeat (3) frame(8'd44, 1'b1, 1'b1);
    repeat (2) frame(8'd44, 1'b1, 1'b0);
    repeat (4) frame(8'd44, 1'b0, 1'b1);
    repeat (40) frame(8'd0, 1'b0, 1'b1);

`ifdef TURN_TIMEOUT_EN
    // Idle timeouts, then a press exactly on the frame frames_left reaches zero.
    repeat (100) frame(8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (m_kind == 0 && m_fl == 1) break;
      frame(8'd0, 1'b0, 1'b1);
    end
    frame(8'd44, 1'b0, 1'b1);
    repeat (40) frame(8'd0, 1'b0, 1'b1);
`endif

    k = 8'd0; pa = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        4, 5:    k = 8'd0;
        6, 7:    k = 8'd44;
        8:       k = 8'd6;
        9:       k = 8'($urandom_range(0, 255));
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) pa = ~pa;
      if ($urandom_range(0, 199) == 0) begin
        repeat (int'($urandom_range(1, 3))) frame(k, pa, 1'b0);
      end
      frame(k, pa, 1'b1);
    end

    repeat (3) @(negedge frame_clk);
    chk("scoreboard_drained", frame_no, exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
